four_bit_divider: RTL and testbench

Sequential 4-bit unsigned restoring divider built around the existing FourBitSubtractor, which it uses as its trial-subtract datapath: one quotient bit per clock, four iterations per division. It consumes the subtractor's difference and borrow each cycle and presents a start/busy/done handshake to the arithmetic control that issues divide operations.

---
 rtl/divider_pkg.sv | 13 +
 rtl/FourBitSubtractor.sv | 19 +
 rtl/four_bit_divider.sv | 140 ++++++++++++++
 tb/tb_four_bit_divider.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the 4-bit restoring divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITERATIONS = 4;
  localparam logic [3:0] DIV0_QUOTIENT = 4'hF;

endpackage

// File: rtl/FourBitSubtractor.sv
// rtl/FourBitSubtractor.sv - 4-bit ripple subtractor used as the trial-subtract datapath
module FourBitSubtractor (
  input  logic       borrowIn,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       borrowOut,
  output logic [3:0] xy
);

  logic [4:0] diff;

  // Widen by one bit so the borrow falls out as the MSB of the difference.
  always_comb begin
    diff      = {1'b0, x} - {1'b0, y} - {4'b0000, borrowIn};
    xy        = diff[3:0];
    borrowOut = diff[4];
  end

endmodule

// File: rtl/four_bit_divider.sv
// rtl/four_bit_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module four_bit_divider
  import divider_pkg::*;
(
  input  logic       clock,
  input  logic       nReset,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       divByZero
);

  state_t     state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [3:0] q_q, q_d;
  logic [3:0] d_q, d_d;
  logic [1:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       div0_q, div0_d;

  logic [3:0] rs;
  logic       r4;
  logic       sub_borrow;
  logic [3:0] sub_diff;
  logic       q_bit;
  logic [3:0] r_next;
  logic [3:0] q_next;

  FourBitSubtractor u_sub (
    .borrowIn (1'b0),
    .x        (rs),
    .y        (d_q),
    .borrowOut(sub_borrow),
    .xy       (sub_diff)
  );

  // Trial subtract: r4 set means the shifted value is >= 16 > D, so the
  // 4-bit difference is correct even though the subtractor reports a borrow.
  always_comb begin
    r4     = r_q[3];
    rs     = {r_q[2:0], q_q[3]};
    q_bit  = r4 | ~sub_borrow;
    r_next = q_bit ? sub_diff : rs;
    q_next = {q_q[2:0], q_bit};
  end

  // Control FSM next-state and register updates.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          if (divisor != 4'd0) begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = 4'd0;
            count_d = 2'd0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            quotient_d  = DIV0_QUOTIENT;
            remainder_d = dividend;
            div0_d      = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        r_d     = r_next;
        q_d     = q_next;
        count_d = count_q + 2'd1;
        if (count_q == 2'(ITERATIONS - 1)) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          div0_d      = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset abandons any division in flight.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      r_q         <= 4'd0;
      q_q         <= 4'd0;
      d_q         <= 4'd0;
      count_q     <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 4'd0;
      remainder_q <= 4'd0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divByZero = div0_q;

endmodule

// File: tb/tb_four_bit_divider.sv
// tb/tb_four_bit_divider.sv - directed self-checking bench for four_bit_divider
module tb_four_bit_divider;

  logic       clock;
  logic       nReset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       divByZero;

  int tests_run;
  int tests_failed;

  four_bit_divider dut (
    .clock    (clock),
    .nReset   (nReset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .divByZero(divByZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Issue one division, wait for done, check latency, busy profile and results.
  task automatic do_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez);
    int n;
    int busy_cnt;
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clock);
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      busy_cnt += int'(busy);
      @(negedge clock);
      n++;
    end
    check_eq({tag, ".lat"}, n, (b != 0) ? 4 : 0);
    check_eq({tag, ".busycyc"}, busy_cnt, (b != 0) ? 4 : 0);
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".q"}, quotient, eq);
    check_eq({tag, ".r"}, remainder, er);
    check_eq({tag, ".dbz"}, divByZero, ez);
  endtask

  initial begin
    int n;
    int seen;
    tests_run    = 0;
    tests_failed = 0;
    nReset   = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clock);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.q", quotient, 0);
    check_eq("rst.r", remainder, 0);
    check_eq("rst.dbz", divByZero, 0);
    nReset = 1'b1;

    do_div("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    @(negedge clock);
    check_eq("13/3.done_pulse", done, 0);
    check_eq("13/3.hold_q", quotient, 4);
    check_eq("13/3.hold_r", remainder, 1);

    do_div("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    do_div("7/9", 4'd7, 4'd9, 4'd0, 4'd7, 1'b0);
    do_div("14/14", 4'd14, 4'd14, 4'd1, 4'd0, 1'b0);
    do_div("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1);
    @(negedge clock);
    check_eq("9/0.done_pulse", done, 0);
    check_eq("9/0.hold_dbz", divByZero, 1);

    // start re-asserted mid-run must be ignored
    @(negedge clock);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clock);
    start = 1'b1; dividend = 4'd2; divisor = 4'd1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("midrun.done", done, 1);
    check_eq("midrun.q", quotient, 4);
    check_eq("midrun.r", remainder, 1);

    // start held through DONE is accepted back-to-back
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clock);
    start = 1'b0;
    check_eq("b2b.busy", busy, 1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("b2b.gap", n, 5);
    check_eq("b2b.q", quotient, 2);
    check_eq("b2b.r", remainder, 2);

    // asynchronous reset during the second iteration
    @(negedge clock);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    nReset = 1'b0;
    #1;
    check_eq("arst.busy", busy, 0);
    check_eq("arst.done", done, 0);
    check_eq("arst.q", quotient, 0);
    check_eq("arst.r", remainder, 0);
    check_eq("arst.dbz", divByZero, 0);
    @(negedge clock);
    nReset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      seen += int'(done) + int'(busy);
    end
    check_eq("arst.no_done", seen, 0);
    do_div("6/4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

    // every operand pair
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div($sformatf("ex%0d/%0d", a, b), 4'(a), 4'(b),
               (b != 0) ? 4'(a / b) : 4'hF,
               (b != 0) ? 4'(a % b) : 4'(a),
               (b == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
